// File: rtl/plot_scanout_if.sv
// Plot-write bus between the simulation side (master) and the display
// framebuffer (slave).
interface plot_scanout_if;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       ready;

    modport master (
        output x,
        output y,
        output colour,
        output plot,
        input  ready
    );

    modport slave (
        input  x,
        input  y,
        input  colour,
        input  plot,
        output ready
    );
endinterface

// File: rtl/plot_scanout.sv
// 160x120x3 framebuffer fed by plot writes, scanned out as 640x480@60 VGA
// with every logical pixel replicated 4x4.
module plot_scanout #(
    parameter logic [2:0] BACKGROUND = 3'b000,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic           clock,
    input  logic           resetn,
    plot_scanout_if.slave  wr,
    output logic           vga_clk,
    output logic           vga_hs,
    output logic           vga_vs,
    output logic           vga_blank_n,
    output logic           vga_r,
    output logic           vga_g,
    output logic           vga_b
);

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [14:0] CLR_LAST  = 15'(FB_DEPTH - 1);
    localparam logic [14:0] FB_W_L    = 15'(FB_W);
    localparam logic [7:0]  FB_W_X    = 8'(FB_W);
    localparam logic [7:0]  FB_H_Y    = 8'(FB_H);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS_L   = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_L   = 10'(V_VIS);
    localparam logic [9:0]  HS_START  = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END    = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START  = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_VIS + V_FP + V_SYNC);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] clr_addr_q, clr_addr_d;
    logic        ce_q, ce_d;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic [2:0]  rgb_q, rgb_d;

    logic [2:0]  fb_mem [FB_DEPTH];
    logic [2:0]  fb_rdata_q;
    logic        fb_we;
    logic [14:0] fb_waddr;
    logic [2:0]  fb_wdata;
    logic [14:0] fb_raddr;

    logic        wr_in_range;
    logic [14:0] wr_addr;
    logic        visible;

    // ------------------------------------------------------------------
    // Control FSM: clear sweep after reset, then accept plot writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + 15'd1;
                if (clr_addr_q == CLR_LAST) begin
                    state_d    = S_RUN;
                    clr_addr_d = '0;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d    = S_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    assign wr.ready = (state_q == S_RUN);

    // ------------------------------------------------------------------
    // Framebuffer write port: clear sweep owns it until RUN.
    // ------------------------------------------------------------------
    assign wr_in_range = (wr.x < FB_W_X) && (wr.y < FB_H_Y);
    assign wr_addr     = 15'(wr.y) * FB_W_L + 15'(wr.x);

    always_comb begin
        fb_we    = 1'b0;
        fb_waddr = clr_addr_q;
        fb_wdata = BACKGROUND;
        if (state_q == S_CLEAR) begin
            fb_we = 1'b1;
        end else if (wr.plot && wr_in_range) begin
            fb_we    = 1'b1;
            fb_waddr = wr_addr;
            fb_wdata = wr.colour;
        end
    end

    // Read-before-write: a same-cycle collision returns the old colour.
    always_ff @(posedge clock) begin
        if (fb_we) begin
            fb_mem[fb_waddr] <= fb_wdata;
        end
        fb_rdata_q <= fb_mem[fb_raddr];
    end

    // ------------------------------------------------------------------
    // Scan timing: ce halves the system clock down to the pixel rate.
    // ------------------------------------------------------------------
    assign visible  = (h_q < H_VIS_L) && (v_q < V_VIS_L);
    assign fb_raddr = visible ? (15'(v_q >> 2) * FB_W_L + 15'(h_q >> 2)) : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ce_q    <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            ce_q    <= ce_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
        end
    end

    // Outputs register the decode of the pixel being left, so sync, blank
    // and colour all trail the counters by the same single pixel.
    always_comb begin
        ce_d    = ~ce_q;
        h_d     = h_q;
        v_d     = v_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        rgb_d   = rgb_q;
        if (ce_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            hs_d    = !((h_q >= HS_START) && (h_q < HS_END));
            vs_d    = !((v_q >= VS_START) && (v_q < VS_END));
            blank_d = visible && (state_q == S_RUN);
            rgb_d   = (visible && (state_q == S_RUN)) ? fb_rdata_q : 3'b000;
        end
    end

    assign vga_clk     = ~ce_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_q;
    assign vga_r       = rgb_q[2];
    assign vga_g       = rgb_q[1];
    assign vga_b       = rgb_q[0];

endmodule

// File: tb/tb_plot_scanout.sv
// Directed-plus-random bench for plot_scanout on a shrunken raster; the
// expected outputs come from clock-count arithmetic and a framebuffer array.
module tb_plot_scanout;

    localparam int HV = 40, HF = 4, HS = 8, HB = 4;
    localparam int VV = 32, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CLEAR_LEN = 19200;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b;

    plot_scanout_if wr_if ();

    plot_scanout #(
        .BACKGROUND (3'b000),
        .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .wr          (wr_if),
        .vga_clk     (vga_clk),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    always #10 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    logic [2:0] fb_model [CLEAR_LEN];
    logic [2:0] snap;
    logic exp_hs, exp_vs, exp_blank;
    logic [2:0] exp_rgb;

    task automatic model_reset();
        n = 0;
        foreach (fb_model[i]) fb_model[i] = 3'b000;
        snap = 3'b000;
        exp_hs = 1'b1;
        exp_vs = 1'b1;
        exp_blank = 1'b0;
        exp_rgb = 3'b000;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at clock %0d", tag, obs, exp, n);
        end
    endtask

    function automatic logic [7:0] observed();
        return {vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, wr_if.ready};
    endfunction

    task automatic drive(input bit pl, input int xx, input int yy, input logic [2:0] c);
        wr_if.plot   = pl;
        wr_if.x      = 8'(xx);
        wr_if.y      = 8'(yy);
        wr_if.colour = c;
    endtask

    task automatic random_inputs();
        int xx, yy;
        xx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(150, 200)) : int'($urandom_range(0, 12));
        yy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(110, 140)) : int'($urandom_range(0, 9));
        drive($urandom_range(0, 2) == 0, xx, yy, 3'($urandom_range(0, 7)));
    endtask

    // One system clock: update the model for the edge, check after it.
    task automatic tick(input string tag);
        int p, h, v;
        bit run_before, vis;
        logic [7:0] exp_vec;
        @(posedge clock);
        if (resetn) begin
            n++;
            run_before = (n - 1) >= CLEAR_LEN;
            p = (n % 2 == 1) ? (n - 1) / 2 : (n - 2) / 2;
            h = p % HT;
            v = (p / HT) % VT;
            vis = (h < HV) && (v < VV);
            if (n % 2 == 1) begin
                snap = vis ? fb_model[(v / 4) * 160 + h / 4] : 3'b000;
            end else begin
                exp_hs    = !(h >= HV + HF && h < HV + HF + HS);
                exp_vs    = !(v >= VV + VF && v < VV + VF + VS);
                exp_blank = vis && run_before;
                exp_rgb   = exp_blank ? snap : 3'b000;
            end
            if (run_before && wr_if.plot && wr_if.x < 160 && wr_if.y < 120)
                fb_model[int'(wr_if.y) * 160 + int'(wr_if.x)] = wr_if.colour;
        end
        @(negedge clock);
        exp_vec = {(n % 2 == 0), exp_hs, exp_vs, exp_blank, exp_rgb, (n >= CLEAR_LEN)};
        check(tag, observed(), exp_vec);
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 3'b000);
        resetn = 1'b0;
        repeat (4) tick("reset_hold");
        resetn = 1'b1;

        // Clear sweep: plots ignored, ready exactly after CLEAR_LEN clocks.
        for (int i = 1; i <= CLEAR_LEN + 10; i++) begin
            if (i == 100) drive(1, 5, 5, 3'b111);
            else if (i == CLEAR_LEN) drive(1, 1, 1, 3'b111);
            else if (i < CLEAR_LEN) random_inputs();
            else drive(0, 0, 0, 3'b000);
            tick(i <= CLEAR_LEN ? "clear" : "ready");
        end

        // Directed corner and out-of-range writes.
        drive(1, 0, 0, 3'b100);    tick("plot_origin");
        drive(1, 159, 119, 3'b011); tick("plot_far_corner");
        drive(1, 160, 10, 3'b111); tick("plot_x_oob");
        drive(1, 10, 120, 3'b111); tick("plot_y_oob");
        drive(1, 9, 7, 3'b101);    tick("plot_vis_corner");
        drive(0, 0, 0, 3'b000);

        for (int i = 0; i < 2 * FRAME; i++) begin
            random_inputs();
            tick("random_run");
        end

        // Collision: write green to (0,0) on the edge that reads pixel 0.
        drive(1, 0, 0, 3'b100);
        tick("collision_prep");
        drive(0, 0, 0, 3'b000);
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            if (n % 2 == 0 && (n / 2) % FRAME == 0) break;
            tick("collision_wait");
        end
        drive(1, 0, 0, 3'b010);
        tick("collision");
        drive(0, 0, 0, 3'b000);
        for (int i = 0; i < 4 * FRAME; i++) tick("post_collision");

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            if ((n / 2) % FRAME == 15 * HT + 20) break;
            random_inputs();
            tick("reset_wait");
        end
        drive(0, 0, 0, 3'b000);
        resetn = 1'b0;
        #1;
        check("async_reset", observed(), 8'b1110_0000);
        model_reset();
        repeat (3) tick("reset_hold2");
        resetn = 1'b1;
        for (int i = 1; i <= CLEAR_LEN + 2 * FRAME + 10; i++) begin
            if (i > CLEAR_LEN) random_inputs();
            else drive(0, 0, 0, 3'b000);
            tick(i <= CLEAR_LEN ? "reclear" : "rerun");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/plot_scanout.md
# plot_scanout

Display-side counterpart to the cell simulation's pixel writer. It accepts plot writes (x, y, colour, plot) on the 160x120 logical grid and stores them in an internal 3-bit framebuffer. It scans that framebuffer out as 640x480@60 Hz VGA timing, with each logical pixel replicated 4x4. It sits between the simulation/control blocks and the board DAC pins, and replaces the write-only view the simulation has of the screen.

## Interface
Parameters:
- BACKGROUND, 3'b000: colour written to every framebuffer entry during the post-reset clear sweep.
- H_VIS / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal pixel counts.
- V_VIS / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical line counts.

Ports:
- clock, in, 1: 50 MHz system clock. One clock domain; no other clocks.
- resetn, in, 1: asynchronous, active-low reset.
- x, in, 8: write column, 0..159 valid.
- y, in, 8: write row, 0..119 valid.
- colour, in, 3: write colour {R,G,B}.
- plot, in, 1: write strobe, sampled every clock.
- ready, out, 1: high once the clear sweep has completed; writes are accepted only while ready=1.
- vga_clk, out, 1: pixel clock, 25 MHz.
- vga_hs, out, 1: horizontal sync, active low.
- vga_vs, out, 1: vertical sync, active low.
- vga_blank_n, out, 1: high during the visible region.
- vga_r, out, 1: red.
- vga_g, out, 1: green.
- vga_b, out, 1: blue.

## Operation
- Framebuffer: 19200 x 3 bits, addressed as y*160 + x. One write port (plot or clear), one synchronous read port (scanout).
- Control states:
  - CLEAR: entered on reset. A 15-bit clear address runs 0..19199, writing BACKGROUND at one entry per clock. plot is ignored and ready=0. At address 19199 the FSM moves to RUN.
  - RUN: ready=1.
- Writes in RUN:
  - plot=1 with x<160 and y<120 writes colour at the addressed entry on that clock edge.
  - Out-of-range coordinates are dropped silently.
  - Back-to-back writes on every clock are supported, with no stall.
- Pixel enable ce: register toggling every clock, reset to 0. ce=1 on every second clock. vga_clk = ~ce, so the DAC samples outputs mid-pixel.
- Scan counters: h 0..799 and v 0..524.
  - On each ce=1 edge, h increments.
  - h wraps 799->0 and increments v.
  - v wraps 524->0.
  - Counters and sync outputs run in both CLEAR and RUN. During CLEAR, vga_blank_n=0 and rgb=0.
- Read address: (v>>2)*160 + (h>>2), taken from the current counters when h<640 and v<480.
- Region decode for counter values (h, v):
  - visible = h<640 && v<480.
  - hs_n = !(656<=h<752).
  - vs_n = !(490<=v<492).
- Outputs: registered on the ce=1 edge from the previous pixel's decode and read data, giving exactly one pixel of delay applied uniformly to sync, blank and colour.
  - vga_r/g/b = colour[2]/[1]/[0] when visible, else 0.
- Read/write collision on the same address in the same cycle: the read returns the old value. The new value appears on the next frame.

## Timing
- Reset (async assert) forces:
  - ce=0, h=0, v=0, state=CLEAR, clear address=0, ready=0.
  - vga_clk=1, vga_hs=1, vga_vs=1, vga_blank_n=0, rgb=0.
- After resetn deasserts:
  - ready rises on the clock edge ending clear address 19199, i.e. 19200 clocks after the first active edge.
  - A plot on the same edge that ready rises is ignored.
- Write-to-display latency: a write lands in memory on its edge. It is visible at the pixel's next scan pass, with outputs one pixel period after the counter reaches the pixel.
- Frame period: 800*525*2 = 840000 clocks.
  - hs low for 96 pixels = 192 clocks per line.
  - vs low for 2 lines = 3200 clocks.
- Reset mid-frame or mid-clear: all state returns to reset values asynchronously and the clear sweep restarts from address 0. Partially written framebuffer contents are overwritten.

## Test plan
- Reset, then release: all outputs hold reset values while resetn=0. ready=0 for exactly 19200 clocks, then 1. A plot of (5,5,3'b111) issued during CLEAR does not appear.
- After ready, plot (0,0,3'b100) and (159,119,3'b011): first visible pixel of the frame has vga_r=1 for 4 pixels x 4 lines. Pixel columns 636..639 on lines 476..479 show g=b=1. All other visible pixels are 0.
- Plot (160,10,3'b111) and (10,120,3'b111): framebuffer unchanged and the full frame reads 0.
- Sync timing: measure vga_hs low for 192 clocks every 1600 clocks. vga_vs low for 3200 clocks every 840000 clocks. vga_blank_n high for 1280 clocks per visible line and low on 45 lines.
- Collision: plot (0,0,3'b010) on the exact cycle the scanout reads address 0. The current frame shows the old colour and the next frame shows green.
- Assert resetn low mid-frame at h=300, v=200: outputs return to reset values immediately. After release, ready=0 again for 19200 clocks and the frame starts at h=0, v=0.
